mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr.sv | 24 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// State encoding and requester identities.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-request round-robin grant logic.
// Bit 0 is instruction fetch, bit 1 is the data path.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                // A tie goes to whoever did not own the port last.
                gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified memory port shared by fetch and load/store.
// Round-robin grant, fixed-latency access, registered response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q, last_d;
    logic              we_q, we_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [1:0]        gnt;
    logic              grant_en;

    // No grant while reset is held: it would be lost.
    assign grant_en = !reset &&
                      ((state_q == IDLE) || (state_q == RESP));

    rr_arbiter2 u_rr (
        .req        ({d_req, if_req}),
        .last_owner (last_q),
        .enable     (grant_en),
        .gnt        (gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_we_d   = 1'b0;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt[1]) begin
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    owner_d  = OWN_D;
                    last_d   = OWN_D;
                    addr_d   = d_addr;
                    we_d     = d_we;
                    wdata_d  = d_wdata;
                    mem_we_d = d_we;
                end else if (gnt[0]) begin
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    owner_d  = OWN_IF;
                    last_d   = OWN_IF;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    if_done_d = (owner_q == OWN_IF);
                    d_done_d  = (owner_q == OWN_D);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= OWN_IF;
            last_q     <= OWN_D;
            we_q       <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign if_gnt    = gnt[0];
    assign d_gnt     = gnt[1];
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MEM_LAT=2.
// Stimulus queues expected completions; a monitor checks them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [63:0] d_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] mem_rdata;
    logic        busy;

    typedef struct {
        logic        d;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    logic [63:0] bmem [0:7];

    mem_port_arbiter #(
        .ADDR_W (64),
        .DATA_W (64),
        .MEM_LAT(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = bmem[mem_addr[5:3]];
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr[5:3]] <= mem_wdata;
    end

    function automatic void chk(string name,
                                logic [63:0] got,
                                logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h",
                      name, got, exp);
    endfunction

    function automatic void push(logic d, logic [63:0] data,
                                 int c);
        exp_t e;
        e.d = d;
        e.data = data;
        e.cyc = c;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (if_done || d_done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected",
                    {62'd0, if_done, d_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("done_owner", {62'd0, if_done, d_done},
                    e.d ? 64'd1 : 64'd2);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("done_rdata", e.d ? d_rdata : if_rdata,
                    e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] ld_data [0:2];

    initial begin
        bmem[0] = 64'h1111; bmem[1] = 64'h2222;
        bmem[2] = 64'hDEAD; bmem[3] = 64'h0;
        bmem[4] = 64'h0;    bmem[5] = 64'h0;
        bmem[6] = 64'h0;    bmem[7] = 64'h0;
        ld_data[0] = 64'h1111;
        ld_data[1] = 64'h2222;
        ld_data[2] = 64'hDEAD;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", if_rdata | d_rdata, 64'd0);
        chk("rst_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);

        // fetch read
        tick(); reset = 1'b0;
        if_req = 1'b1; if_addr = 64'h10;
        @(negedge clk);
        chk("f_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        push(1'b0, 64'hDEAD, cyc + 3);
        tick(); if_req = 1'b0; if_addr = 64'h99;
        @(negedge clk);
        chk("f_addr1", mem_addr, 64'h10);
        chk("f_we1", 64'(mem_we), 64'd0);
        chk("f_busy1", 64'(busy), 64'd1);
        tick(); @(negedge clk);
        chk("f_addr2", mem_addr, 64'h10);
        tick(); @(negedge clk);
        chk("f_busy3", 64'(busy), 64'd1);
        tick(); @(negedge clk);
        chk("f_idle", 64'(busy), 64'd0);

        // back-to-back loads
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0;
        @(negedge clk);
        chk("ld_gnt0", 64'(d_gnt), 64'd1);
        push(1'b1, ld_data[0], cyc + 3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) d_addr = 64'h8;
            if (k == 4) d_addr = 64'h10;
            @(negedge clk);
            if (k == 3 || k == 6) begin
                chk("ld_gnt", 64'(d_gnt), 64'd1);
                push(1'b1, ld_data[k/3], cyc + 3);
            end else begin
                chk("ld_nogn", 64'(d_gnt), 64'd0);
            end
        end
        tick(); d_req = 1'b0;
        repeat (4) tick();
        chk("ld_if_hold", if_rdata, 64'hDEAD);

        // store
        d_req = 1'b1; d_we = 1'b1;
        d_addr = 64'h20; d_wdata = 64'hAB;
        @(negedge clk);
        chk("st_gnt", 64'(d_gnt), 64'd1);
        push(1'b1, 64'hDEAD, cyc + 3);
        tick(); d_req = 1'b0; d_wdata = 64'h0;
        @(negedge clk);
        chk("st_we1", 64'(mem_we), 64'd1);
        chk("st_wdata", mem_wdata, 64'hAB);
        chk("st_addr", mem_addr, 64'h20);
        tick(); @(negedge clk);
        chk("st_we2", 64'(mem_we), 64'd0);
        chk("st_wd_hold", mem_wdata, 64'hAB);
        repeat (3) tick();

        // both held: IF, D, IF, D
        if_req = 1'b1; if_addr = 64'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            if (k % 3 == 0) begin
                if ((k / 3) % 2 == 0) begin
                    chk("alt_gnt", {62'd0, if_gnt, d_gnt},
                        64'd2);
                    push(1'b0, 64'h2222, cyc + 3);
                end else begin
                    chk("alt_gnt", {62'd0, if_gnt, d_gnt},
                        64'd1);
                    push(1'b1, 64'hAB, cyc + 3);
                end
            end else begin
                chk("alt_nogn", {62'd0, if_gnt, d_gnt}, 64'd0);
            end
        end
        tick(); if_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();

        // reset during a store
        d_req = 1'b1; d_we = 1'b1;
        d_addr = 64'h28; d_wdata = 64'h55;
        @(negedge clk);
        chk("rs_gnt", 64'(d_gnt), 64'd1);
        tick(); d_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rs_we1", 64'(mem_we), 64'd1);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_we", 64'(mem_we), 64'd0);
        chk("rs_addr", mem_addr, 64'd0);
        chk("rs_wdata", mem_wdata, 64'd0);
        chk("rs_rdata", if_rdata | d_rdata, 64'd0);
        repeat (4) tick();

        // tie right after reset goes to fetch
        if_req = 1'b1; if_addr = 64'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h28;
        @(negedge clk);
        chk("tie_gnt0", {62'd0, if_gnt, d_gnt}, 64'd2);
        push(1'b0, 64'hDEAD, cyc + 3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) if_req = 1'b0;
            @(negedge clk);
            if (k == 3) begin
                chk("tie_gnt3", {62'd0, if_gnt, d_gnt},
                    64'd1);
                push(1'b1, 64'h55, cyc + 3);
            end else begin
                chk("tie_nogn", {62'd0, if_gnt, d_gnt}, 64'd0);
            end
        end
        tick(); d_req = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
